q2_panel: RTL

Q2_PANEL -- requirements
Module: q2_panel

---
 rtl/q2_panel_pkg.sv | 24 ++
 rtl/q2_debounce.sv | 66 ++++++
 rtl/q2_panel.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/q2_panel_pkg.sv
// Shared definitions for the q2_panel front-panel conditioner.
// Provides the sequencer state type, button indices and parameter defaults.
package q2_panel_pkg;

  localparam int unsigned DefDebTicks = 1000;
  localparam int unsigned DefDebCount = 4;
  localparam int unsigned DefPulseW   = 4;

  // Bit positions of the momentary buttons in the internal button vector
  localparam int unsigned BtnDep   = 0;
  localparam int unsigned BtnIncp  = 1;
  localparam int unsigned BtnStart = 2;
  localparam int unsigned BtnStop  = 3;
  localparam int unsigned NumBtn   = 4;

  typedef enum logic [2:0] {
    StIdle,
    StDep,
    StIncp,
    StGap,
    StWaitRel
  } seq_state_e;

endpackage

// File: rtl/q2_debounce.sv
// Single-button conditioner: 2-flop synchronizer, tick-sampled agreement
// counter and debounced level.
// Ports: clk_i, rst_ni (async, active-low), tick_i (shared prescaler tick),
//        raw_i (raw button), level_o (debounced level), rise_o (one-clock
//        pulse coincident with the level going high).
module q2_debounce
  import q2_panel_pkg::*;
#(
  parameter int unsigned DEB_COUNT = DefDebCount
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tick_i,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam int unsigned       CntW    = (DEB_COUNT > 1) ? $clog2(DEB_COUNT) : 1;
  localparam logic [CntW-1:0]   CntLast = CntW'(DEB_COUNT - 1);

  logic            sync1_q, sync2_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            rise_q, rise_d;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    if (tick_i) begin
      if (sync2_q != level_q) begin
        // Counter holds DEB_COUNT-1 on the tick that completes the run
        if (cnt_q == CntLast) begin
          level_d = ~level_q;
          cnt_d   = '0;
          rise_d  = ~level_q;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/q2_panel.sv
// Front-panel conditioner: synchronizes switches, debounces four buttons and
// sequences clean deposit / increment-PC pulses plus start / stop pulses.
// Ports: clk, rst (async, active-low), sw_raw[11:0], incp_raw, dep_raw,
//        start_raw, stop_raw (raw inputs); sw[11:0] (switch word, frozen while
//        busy), incp_sw, dep_sw, start_sw, stop_sw (PULSE_W-clock pulses),
//        busy (sequencer not idle). All outputs are registered.
module q2_panel
  import q2_panel_pkg::*;
#(
  parameter int unsigned DEB_TICKS = DefDebTicks,
  parameter int unsigned DEB_COUNT = DefDebCount,
  parameter int unsigned PULSE_W   = DefPulseW
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] sw_raw,
  input  logic        incp_raw,
  input  logic        dep_raw,
  input  logic        start_raw,
  input  logic        stop_raw,
  output logic [11:0] sw,
  output logic        incp_sw,
  output logic        dep_sw,
  output logic        start_sw,
  output logic        stop_sw,
  output logic        busy
);

  localparam int unsigned     PreW    = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
  localparam int unsigned     PwW     = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
  localparam logic [PreW-1:0] PreLast = PreW'(DEB_TICKS - 1);
  localparam logic [PwW-1:0]  PwLast  = PwW'(PULSE_W - 1);

  logic [PreW-1:0]   pre_q, pre_d;
  logic              tick;
  logic [NumBtn-1:0] btn_raw, btn_level, btn_rise;
  logic              unused_level;

  logic [11:0] sw_sync1_q, sw_sync2_q, sw_q, sw_d;
  seq_state_e  state_q, state_d;
  logic [PwW-1:0] pcnt_q, pcnt_d;
  logic        pend_q, pend_d;
  logic        dep_sw_q, dep_sw_d, incp_sw_q, incp_sw_d, busy_q, busy_d;
  logic        start_q, start_d, stop_q, stop_d;
  logic [PwW-1:0] start_cnt_q, start_cnt_d, stop_cnt_q, stop_cnt_d;
  logic        start_fire, stop_fire;

  // Shared prescaler
  assign tick  = (pre_q == PreLast);
  assign pre_d = tick ? '0 : pre_q + PreW'(1);

  assign btn_raw = {stop_raw, start_raw, incp_raw, dep_raw};

  for (genvar i = 0; i < NumBtn; i++) begin : g_btn
    q2_debounce #(
      .DEB_COUNT(DEB_COUNT)
    ) u_deb (
      .clk_i  (clk),
      .rst_ni (rst),
      .tick_i (tick),
      .raw_i  (btn_raw[i]),
      .level_o(btn_level[i]),
      .rise_o (btn_rise[i])
    );
  end

  // start/stop levels are not needed; only their edges matter
  assign unused_level = ^btn_level[BtnStop:BtnStart];

  // Deposit / increment-PC sequencer
  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    pend_d  = pend_q;
    unique case (state_q)
      StIdle: begin
        if (btn_rise[BtnDep]) begin
          state_d = StDep;
          pcnt_d  = '0;
          pend_d  = btn_rise[BtnIncp];
        end else if (btn_rise[BtnIncp]) begin
          state_d = StIncp;
          pcnt_d  = '0;
        end
      end
      StDep, StIncp: begin
        if (pcnt_q == PwLast) begin
          state_d = StGap;
          pcnt_d  = '0;
        end else begin
          pcnt_d = pcnt_q + PwW'(1);
        end
      end
      StGap: begin
        if (pcnt_q == PwLast) begin
          pcnt_d = '0;
          if (pend_q) begin
            state_d = StIncp;
            pend_d  = 1'b0;
          end else begin
            state_d = StWaitRel;
          end
        end else begin
          pcnt_d = pcnt_q + PwW'(1);
        end
      end
      StWaitRel: begin
        if (!btn_level[BtnDep] && !btn_level[BtnIncp]) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs follow the next state so they line up with the state register
    dep_sw_d  = (state_d == StDep);
    incp_sw_d = (state_d == StIncp);
    busy_d    = (state_d != StIdle);
    sw_d      = (state_q == StIdle) ? sw_sync2_q : sw_q;
  end

  // Independent start / stop pulse generators; stop has priority over start
  always_comb begin
    stop_fire  = btn_rise[BtnStop] & ~stop_q;
    start_fire = btn_rise[BtnStart] & ~start_q & ~btn_rise[BtnStop];

    start_d     = start_q;
    start_cnt_d = start_cnt_q;
    if (start_q) begin
      if (start_cnt_q == PwLast) begin
        start_d = 1'b0;
      end else begin
        start_cnt_d = start_cnt_q + PwW'(1);
      end
    end
    if (start_fire) begin
      start_d     = 1'b1;
      start_cnt_d = '0;
    end
    if (stop_fire) begin
      start_d = 1'b0;
    end

    stop_d     = stop_q;
    stop_cnt_d = stop_cnt_q;
    if (stop_q) begin
      if (stop_cnt_q == PwLast) begin
        stop_d = 1'b0;
      end else begin
        stop_cnt_d = stop_cnt_q + PwW'(1);
      end
    end
    if (stop_fire) begin
      stop_d     = 1'b1;
      stop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q       <= '0;
      sw_sync1_q  <= '0;
      sw_sync2_q  <= '0;
      sw_q        <= '0;
      state_q     <= StIdle;
      pcnt_q      <= '0;
      pend_q      <= 1'b0;
      dep_sw_q    <= 1'b0;
      incp_sw_q   <= 1'b0;
      busy_q      <= 1'b0;
      start_q     <= 1'b0;
      start_cnt_q <= '0;
      stop_q      <= 1'b0;
      stop_cnt_q  <= '0;
    end else begin
      pre_q       <= pre_d;
      sw_sync1_q  <= sw_raw;
      sw_sync2_q  <= sw_sync1_q;
      sw_q        <= sw_d;
      state_q     <= state_d;
      pcnt_q      <= pcnt_d;
      pend_q      <= pend_d;
      dep_sw_q    <= dep_sw_d;
      incp_sw_q   <= incp_sw_d;
      busy_q      <= busy_d;
      start_q     <= start_d;
      start_cnt_q <= start_cnt_d;
      stop_q      <= stop_d;
      stop_cnt_q  <= stop_cnt_d;
    end
  end

  assign sw       = sw_q;
  assign dep_sw   = dep_sw_q;
  assign incp_sw  = incp_sw_q;
  assign busy     = busy_q;
  assign start_sw = start_q;
  assign stop_sw  = stop_q;

endmodule
